// File: rtl/bcd_serial_adder.sv
// +----------------------------------------------------------------------+
// | bcd_serial_adder: digit-serial packed-BCD add / nines-complement sub |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module bcd_serial_adder #(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  input  logic                sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             sub_q, sub_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             err_q, err_d;

  logic [3:0]       a_dig, b_dig, bd;
  logic [4:0]       raw;
  logic             raw_gt9;
  logic [3:0]       res_dig;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;

    // Current digit slice and its decimal-corrected sum
    a_dig   = a_q[{idx_q, 2'b00} +: 4];
    b_dig   = b_q[{idx_q, 2'b00} +: 4];
    bd      = sub_q ? (4'd9 - b_dig) : b_dig;
    raw     = {1'b0, a_dig} + {1'b0, bd} + {4'd0, carry_q};
    raw_gt9 = (raw > 5'd9);
    res_dig = raw_gt9 ? (raw[3:0] + 4'd6) : raw[3:0];

    case (state_q)
      S_IDLE: begin
        if (in_valid && rst_n) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[{idx_q, 2'b00} +: 4] = res_dig;
        carry_d = raw_gt9;
        err_d   = err_q | (a_dig > 4'd9) | (b_dig > 4'd9);
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = raw_gt9;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE) && rst_n;
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_serial_adder.sv
// Directed self-checking bench for bcd_serial_adder (DIGITS=2 and DIGITS=4 instances).
`default_nettype none

module tb_bcd_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, err;
  logic [7:0]  a, b, sum;
  logic        in_valid4, in_ready4, cin4, sub4, out_valid4, out_ready4, cout4, err4;
  logic [15:0] a4, b4, sum4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_serial_adder #(.DIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .err(err)
  );

  bcd_serial_adder #(.DIGITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .sub(sub4), .out_valid(out_valid4),
    .out_ready(out_ready4), .sum(sum4), .cout(cout4), .err(err4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One DIGITS=2 transaction: optional junk in_valid during RUN, optional hold in DONE.
  task automatic op2(input string tag, input logic [7:0] av, input logic [7:0] bv,
                     input logic cv, input logic sv, input logic [7:0] es,
                     input logic ec, input logic ee, input logic pulse, input int hold);
    int lat;
    int n;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    chk({tag, "_in_ready"}, in_ready, 1);
    a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    if (pulse) begin
      a = 8'h11; b = 8'h22; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    end
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    in_valid = 1'b0;
    chk({tag, "_latency"}, lat, 2);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_err"}, err, ee);
    chk({tag, "_ready_in_done"}, in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_sum"}, sum, es);
      chk({tag, "_hold_cout"}, cout, ec);
      chk({tag, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_post_in_ready"}, in_ready, 1);
    chk({tag, "_post_out_valid"}, out_valid, 0);
    chk({tag, "_post_sum_kept"}, sum, es);
  endtask

  initial begin
    int lat4;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;

    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    tick();
    chk("rel_in_ready", in_ready, 1);

    op2("add45_38", 8'h45, 8'h38, 1'b0, 1'b0, 8'h83, 1'b0, 1'b0, 1'b0, 0);
    op2("add99_99c", 8'h99, 8'h99, 1'b1, 1'b0, 8'h99, 1'b1, 1'b0, 1'b0, 0);
    op2("sub52_17", 8'h52, 8'h17, 1'b0, 1'b1, 8'h35, 1'b1, 1'b0, 1'b0, 0);
    op2("sub17_52", 8'h17, 8'h52, 1'b0, 1'b1, 8'h65, 1'b0, 1'b0, 1'b0, 0);
    op2("add4A_01", 8'h4A, 8'h01, 1'b0, 1'b0, 8'h51, 1'b0, 1'b1, 1'b0, 0);
    op2("add01_01", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 0);
    op2("bp_pulse", 8'h27, 8'h36, 1'b1, 1'b0, 8'h64, 1'b0, 1'b0, 1'b1, 5);

    // Reset landing on the first RUN edge aborts the operation.
    a = 8'h58; b = 8'h67; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("abort_out_valid", out_valid, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    chk("abort_err", err, 0);
    chk("abort_in_ready", in_ready, 0);
    rst_n = 1'b1;
    tick();
    chk("abort_rel_in_ready", in_ready, 1);
    tick();
    tick();
    chk("abort_no_result", out_valid, 0);

    // Wider instance: 9999 + 0001
    a4 = 16'h9999; b4 = 16'h0001; cin4 = 1'b0; sub4 = 1'b0;
    chk("w4_in_ready", in_ready4, 1);
    in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    lat4 = 0;
    while (!out_valid4 && lat4 < 20) begin tick(); lat4++; end
    chk("w4_latency", lat4, 4);
    chk("w4_sum", sum4, 16'h0000);
    chk("w4_cout", cout4, 1);
    chk("w4_err", err4, 0);
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    chk("w4_post_in_ready", in_ready4, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
